// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-through, no-write-allocate data cache that sits between
// the MEM stage and main memory. Storage is flip-flop based. Each set holds a
// valid bit, a tag and WORDS data words.
//
// Behaviour:
//   - A read hit returns data in the same cycle with no stall.
//   - A read miss refills the whole line, one word per mem_ready beat.
//   - Every write goes to memory. A write that hits also updates the cached
//     word. A write that misses leaves the cache unchanged.
//
// Handshake: mem_rd or mem_wr asserts a request. mem_addr and mem_wdata stay
// stable while the request is pending. A cycle with mem_ready=1 completes
// exactly one word, either a refill beat or the single write-through beat.
//
// Parameters:
//   SETS  number of lines (power of two, >= 2)
//   WORDS 32-bit words per line (power of two, >= 2)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_rd, cpu_wr      load / store request (both high => store)
//   cpu_addr, cpu_wdata byte address (bits [1:0] ignored), store data
//   cpu_rdata           combinational load data from the array
//   stall               memory-system stall to the hazard unit
//   mem_rd, mem_wr      registered refill / write-through requests
//   mem_addr, mem_wdata registered word-aligned address and store data
//   mem_rdata, mem_ready refill data and per-word handshake from memory
//
// Optional feature (macro DCACHE_STATS_EN):
//   Adds the outputs hit_count and miss_count. Both are 32-bit wrapping
//   counters.
//   hit_count counts reads that hit on their first evaluation in IDLE.
//   miss_count counts entries into FILL.
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int SETS  = 64,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IW = $clog2(SETS);
    localparam int OW = $clog2(WORDS);
    localparam int TW = 32 - IW - OW - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_WDONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [OW-1:0] cnt_q, cnt_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          valid_q [SETS];
    logic          valid_d [SETS];
    logic [TW-1:0] tag_q   [SETS];
    logic [TW-1:0] tag_d   [SETS];
    logic [31:0]   data_q  [SETS][WORDS];
    logic [31:0]   data_d  [SETS][WORDS];

    // Request address fields.
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [OW-1:0] req_word;
    logic          hit;
    logic          stall_raw;

    // The refill target is taken from the registered refill address rather
    // than from cpu_addr. That keeps the refill self-contained even if the
    // pipeline-side address wobbles.
    logic [TW-1:0] fill_tag;
    logic [IW-1:0] fill_idx;

    logic unused_addr_bits;

    assign req_tag  = cpu_addr[31:IW+OW+2];
    assign req_idx  = cpu_addr[IW+OW+1:OW+2];
    assign req_word = cpu_addr[OW+1:2];
    assign fill_tag = mem_addr_q[31:IW+OW+2];
    assign fill_idx = mem_addr_q[IW+OW+1:OW+2];
    assign unused_addr_bits = ^{cpu_addr[1:0], mem_addr_q[1:0]};

    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cpu_rdata = data_q[req_idx][req_word];

    // Stall is forced low while reset is asserted. An aborted refill then
    // releases the pipeline at once, even with the load still presented.
    assign stall     = stall_raw && rst_n;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    // Marks the IDLE cycle right after a refill. The held load hits in that
    // cycle, but the hit is the tail of a miss and is not counted.
    logic        refilled_q, refilled_d;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state, outputs and array updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        stall_raw   = 1'b0;
`ifdef DCACHE_STATS_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        refilled_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (cpu_wr) begin
                    // Store, hit or miss: write through to memory. A hit
                    // also updates the cached copy.
                    stall_raw   = 1'b1;
                    if (hit) begin
                        data_d[req_idx][req_word] = cpu_wdata;
                    end
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = {cpu_addr[31:2], 2'b00};
                    mem_wdata_d = cpu_wdata;
                    state_d     = S_WRITE;
                end else if (cpu_rd) begin
                    if (hit) begin
`ifdef DCACHE_STATS_EN
                        if (!refilled_q) begin
                            hit_count_d = hit_count_q + 32'd1;
                        end
`endif
                    end else begin
                        // The line is invalidated now. Its words are
                        // overwritten beat by beat during the refill.
                        stall_raw        = 1'b1;
                        valid_d[req_idx] = 1'b0;
                        cnt_d            = '0;
                        mem_rd_d         = 1'b1;
                        mem_addr_d       = {req_tag, req_idx, {OW{1'b0}}, 2'b00};
                        state_d          = S_FILL;
`ifdef DCACHE_STATS_EN
                        miss_count_d     = miss_count_q + 32'd1;
`endif
                    end
                end
            end

            S_FILL: begin
                stall_raw = 1'b1;
                if (mem_ready) begin
                    data_d[fill_idx][cnt_q] = mem_rdata;
                    cnt_d      = cnt_q + OW'(1);
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (cnt_q == OW'(WORDS - 1)) begin
                        tag_d[fill_idx]   = fill_tag;
                        valid_d[fill_idx] = 1'b1;
                        mem_rd_d          = 1'b0;
                        state_d           = S_IDLE;
`ifdef DCACHE_STATS_EN
                        refilled_d        = 1'b1;
`endif
                    end
                end
            end

            S_WRITE: begin
                stall_raw = 1'b1;
                if (mem_ready) begin
                    mem_wr_d = 1'b0;
                    state_d  = S_WDONE;
                end
            end

            S_WDONE: begin
                // One unstalled cycle lets the frozen store retire. The
                // request still presented here is that store, so it is not
                // evaluated again.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 1'b0;
                tag_q[s]   <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            refilled_q   <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            refilled_q   <= refilled_d;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//
// Bench for dcache_controller with default parameters (64 sets, 4 words).
//
// The reference model is transaction level:
//   - per-set valid and tag arrays,
//   - a sparse main-memory array,
//   - the spec's stall-length arithmetic.
//
// Each request precomputes its per-cycle stall profile and the memory beats
// it must produce. The compare process checks DUT outputs against these on
// every falling edge. The same process acts as the memory: it waits a
// precomputed number of cycles per beat before raising mem_ready.
//
// Handshake: mem_rd or mem_wr is held until a cycle with mem_ready=1. That
// cycle completes one word.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model state and expectation queues
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int          total;
  int          bad;
  logic        exp_stall;
  logic        exp_rd_chk;
  logic [31:0] exp_rdata;
  beat_t       exp_q[$];    // memory beats the DUT must still issue
  int          w_q[$];      // per-beat memory wait, consumed by the responder
  logic [31:0] mem_m [logic [31:0]];
  logic        cv [64];
  logic [21:0] ct [64];
  int          stall_cycles;
  int          model_hits;
  int          model_misses;
  bit          in_beat;
  int          beat_cnt;
  int          cur_w;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5EED_0000;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process plus memory responder (falling edge)
  // ---------------------------------------------------------------------------
  task automatic compare_loop();
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0;
        in_beat   = 1'b0;
      end else begin
        check32("stall", {31'd0, stall}, {31'd0, exp_stall});
        if (stall) stall_cycles++;
        if (exp_rd_chk) check32("cpu_rdata", cpu_rdata, exp_rdata);
        mem_ready = 1'b0;
        if (mem_rd || mem_wr) begin
          if (exp_q.size() == 0) begin
            check32("unexpected_mem_req", {30'd0, mem_rd, mem_wr}, 32'd0);
          end else begin
            b = exp_q[0];
            check32("mem_rd", {31'd0, mem_rd}, {31'd0, ~b.wr});
            check32("mem_wr", {31'd0, mem_wr}, {31'd0, b.wr});
            check32("mem_addr", mem_addr, b.addr);
            if (b.wr) check32("mem_wdata", mem_wdata, b.data);
            if (!in_beat) begin
              in_beat  = 1'b1;
              beat_cnt = 0;
              cur_w    = (w_q.size() > 0) ? w_q.pop_front() : 0;
            end
            if (beat_cnt == cur_w) begin
              mem_ready = 1'b1;
              mem_rdata = mem_word(mem_addr);
              in_beat   = 1'b0;
              void'(exp_q.pop_front());
            end else begin
              beat_cnt++;
            end
          end
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic s, input logic chk, input logic [31:0] rd);
    exp_stall  = s;
    exp_rd_chk = chk;
    exp_rdata  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle(input int n);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  // wfix < 0 draws a random wait per beat.
  task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int wfix);
    logic [31:0] a;
    logic [31:0] line;
    logic [21:0] tag;
    int          idx;
    bit          hit;
    int          w;
    int          n;
    a    = {addr[31:2], 2'b00};
    line = {a[31:4], 4'b0000};
    idx  = int'(a[9:4]);
    tag  = a[31:10];
    hit  = cv[idx] && (ct[idx] == tag);
    cpu_rd       = rd;
    cpu_wr       = wr;
    cpu_addr     = addr;
    cpu_wdata    = data;
    stall_cycles = 0;
    if (wr) begin
      w = (wfix < 0) ? int'($urandom_range(0, 3)) : wfix;
      w_q.push_back(w);
      exp_q.push_back('{wr: 1'b1, addr: a, data: data});
      mem_m[a] = data;
      n = 1 + (w + 1);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);  // store retires
    end else if (hit) begin
      model_hits++;
      step(1'b0, 1'b1, mem_word(a));
    end else begin
      model_misses++;
      n = 1;
      for (int k = 0; k < 4; k++) begin
        w = (wfix < 0) ? int'($urandom_range(0, 3)) : wfix;
        w_q.push_back(w);
        exp_q.push_back('{wr: 1'b0, addr: line + 32'(4 * k), data: 32'd0});
        n += w + 1;
      end
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0);
      cv[idx] = 1'b1;
      ct[idx] = tag;
      step(1'b0, 1'b1, mem_word(a));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    int          op;
    total = 0;
    bad = 0;
    model_hits = 0;
    model_misses = 0;
    stall_cycles = 0;
    in_beat = 1'b0;
    beat_cnt = 0;
    cur_w = 0;
    exp_stall = 1'b0;
    exp_rd_chk = 1'b0;
    exp_rdata = 32'd0;
    rst_n = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = 32'd0;
    cpu_wdata = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    for (int s = 0; s < 64; s++) begin
      cv[s] = 1'b0;
      ct[s] = '0;
    end
    for (int k = 0; k < 4; k++) mem_m[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);

    fork
      compare_loop();
    join_none

    // Reset values
    #12;
    check32("rst_stall", {31'd0, stall}, 32'd0);
    check32("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check32("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_cpu_rdata", cpu_rdata, 32'd0);
`ifdef DCACHE_STATS_EN
    check32("rst_hit_count", hit_count, 32'd0);
    check32("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_idle(2);

    // Refill of 0x100 with W=2: 1 + 4*3 = 13 stall cycles
    do_req(1'b0, 1'b1, 32'h100, 32'd0, 2);
    check32("miss_stall_len", 32'(stall_cycles), 32'd13);
    check32("lit_rd_100", cpu_rdata, 32'hA0);
    // Same line, other word: hit with no stall
    do_req(1'b0, 1'b1, 32'h104, 32'd0, 0);
    check32("hit_stall_len", 32'(stall_cycles), 32'd0);
    check32("lit_rd_104", cpu_rdata, 32'hA1);
`ifdef DCACHE_STATS_EN
    check32("lit_miss_count", miss_count, 32'd1);
    check32("lit_hit_count", hit_count, 32'd1);
`endif

    // Write hit 0x108, W=0: 2 stall cycles, then a read returns the new word
    do_req(1'b1, 1'b0, 32'h108, 32'h0000DEAD, 0);
    check32("wr_stall_len", 32'(stall_cycles), 32'd2);
    do_req(1'b0, 1'b1, 32'h108, 32'd0, 0);
    check32("rd_after_wr_stall", 32'(stall_cycles), 32'd0);
    check32("lit_rd_108", cpu_rdata, 32'h0000DEAD);

    // Write miss 0x2000 does not allocate; the next read refills
    do_req(1'b1, 1'b0, 32'h2000, 32'h12345678, 1);
    check32("wr_miss_stall_len", 32'(stall_cycles), 32'd3);
    do_req(1'b0, 1'b1, 32'h2000, 32'd0, 0);
    check32("rd_2000_stall_len", 32'(stall_cycles), 32'd5);
    check32("lit_rd_2000", cpu_rdata, 32'h12345678);

    // Conflict: 0x1100 evicts 0x100, which then misses again
    do_req(1'b0, 1'b1, 32'h1100, 32'd0, 0);
    check32("conflict_stall_len", 32'(stall_cycles), 32'd5);
    do_req(1'b0, 1'b1, 32'h100, 32'd0, 0);
    check32("remiss_stall_len", 32'(stall_cycles), 32'd5);
    check32("lit_rd_100_again", cpu_rdata, 32'hA0);
    do_idle(1);

    // Reset two beats into a refill of 0x300
    cpu_rd = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      w_q.push_back(0);
      exp_q.push_back('{wr: 1'b0, addr: 32'h300 + 32'(4 * k), data: 32'd0});
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    check32("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    check32("abort_stall", {31'd0, stall}, 32'd0);
    exp_q.delete();
    w_q.delete();
    for (int s = 0; s < 64; s++) cv[s] = 1'b0;
    model_hits = 0;
    model_misses = 0;
    exp_stall = 1'b0;
    exp_rd_chk = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(1'b0, 1'b1, 32'h300, 32'd0, 0);
    check32("refill_after_abort_len", 32'(stall_cycles), 32'd5);

    // Randomized traffic over a few sets and tags to mix hits, misses and
    // conflicts
    for (int t = 0; t < 300; t++) begin
      op = int'($urandom_range(0, 9));
      ra = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (op <= 1)      do_idle(int'($urandom_range(1, 2)));
      else if (op <= 5) do_req(1'b0, 1'b1, ra, 32'd0, -1);
      else if (op <= 8) do_req(1'b1, 1'b0, ra, $urandom, -1);
      else              do_req(1'b1, 1'b1, ra, $urandom, -1);
    end
    do_idle(3);

    check32("beats_outstanding", 32'(exp_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
    check32("final_hit_count", hit_count, 32'(model_hits));
    check32("final_miss_count", miss_count, 32'(model_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
